pc_seq: RTL
===========

// Module: pc_seq
// PURPOSE
//  Program counter / fetch sequencer for the RISC8 core. Owns the PC, the
//  return stack and the instruction register that feeds the instruction
//  decoder. It resolves GOTO, CALL, RETLW, PCL writes and conditional skips
//  (DECFSZ, INCFSZ, BTFSC, BTFSS) by squashing the instruction just fetched.
//  One instruction retires per clock, with a one-stage fetch/execute overlap.
// PARAMETERS
//  PC_WIDTH     11     PC/ROM address width; legal range 9..11
//  STACK_DEPTH  2      return stack entries; must be >= 1
//  RESET_VEC    {PC_WIDTH{1'b1}}  PC value on reset
// PORTS
//  clk        in   1         clock; all state is updated on the rising edge
//  reset      in   1         asynchronous, active-high reset
//  stall      in   1         1 = hold all state (sleep/wait)
//  romaddr    out  PC_WIDTH  fetch address; equals the PC register
//  romdata    in   12        ROM word at romaddr, same cycle (combinational ROM)
//  inst       out  12        executing instruction, registered, to the decoder
//  squashed   out  1         1 = inst is a NOP inserted by a flush
//  aluz       in   1         ALU result zero for the executing instruction
//  pclwe      in   1         executing instruction writes file register PCL
//  pclin      in   8         data being written to PCL
//  pa         in   2         STATUS page bits; low PC_WIDTH-9 bits used
//  stk_ovf    out  1         sticky: push onto a full stack
//  stk_unf    out  1         sticky: pop from an empty stack
// BEHAVIOUR
//  Reset (async) values:
//  - pc = RESET_VEC; inst = 12'h000 (NOP); squashed = 1.
//  - All stack entries = 0; stack count = 0; stk_ovf = stk_unf = 0.
//  Each unstalled cycle:
//  - inst <= flush ? 12'h000 : romdata; squashed <= flush.
//  - pc <= next_pc.
//  - Default next_pc = pc+1, wrapping from all-ones to 0.
//  Event decode on inst, evaluated in the priority order below (first match wins):
//  1. RETLW 1000_kkkk_kkkk: next_pc = pop; flush=1.
//  2. CALL  1001_kkkk_kkkk: push pc (already CALL+1);
//     next_pc = {pa, 1'b0, k[7:0]}; flush=1.
//  3. GOTO  101k_kkkk_kkkk: next_pc = {pa, k[8:0]}; flush=1.
//  4. pclwe=1: next_pc = {pa, 1'b0, pclin}; flush=1.
//     Applies to any instruction, including skip opcodes; the skip is ignored.
//  5. Skip taken: next_pc = pc+1; flush=1, so the fetched word is discarded.
//     - DECFSZ 0010_11xx_xxxx or INCFSZ 0011_11xx_xxxx: taken when aluz=1.
//     - BTFSC 0110_xxxx_xxxx: taken when aluz=1.
//     - BTFSS 0111_xxxx_xxxx: taken when aluz=0.
//  6. Otherwise: flush=0.
//  Squash rules:
//  - A squashed NOP never triggers an event; it does not reach item 5.
//  - A flush therefore costs exactly 1 bubble cycle.
//  Page bits:
//  - Truncate {pa,...} to PC_WIDTH; PC_WIDTH=9 ignores pa entirely.
//  Stack (LIFO, count 0..STACK_DEPTH):
//  - Push when full: deepest entry is lost, entries shift, new value on top;
//    count stays full; stk_ovf <= 1.
//  - Pop when empty: returns the current top entry (last value, unchanged);
//    count stays 0; stk_unf <= 1.
//  - stk_ovf and stk_unf clear only on reset.
//  stall=1:
//  - pc, inst, squashed, stack and flags all hold.
//  - Event decode is suppressed; it happens in the first unstalled cycle,
//    using aluz/pclwe as presented in that cycle.
//  - romaddr stays at pc.
//  Reset mid-flush or mid-stall: reset wins immediately; state returns to
//  reset values.
// TESTING
//  - Reset, romdata=12'h000 -> romaddr=7FF; next cycle 000, then 001; squashed
//    1 then 0.
//  - CALL 0x955 at 0x010 with pa=2'b01, then RETLW at 0x255 -> pc 0x011, then
//    0x255; stack holds 0x011; RETLW -> pc 0x011; each flush inserts one NOP.
//  - DECFSZ with aluz=1 at 0x020 -> word at 0x021 squashed, execution resumes
//    at 0x022; repeat with aluz=0 -> no squash.
//  - BTFSS aluz=0 -> skip; BTFSC aluz=0 -> no skip; BTFSC while stall=1 for
//    3 cycles -> pc/inst hold, skip resolved on release.
//  - Three nested CALLs (depth 2) -> stk_ovf=1, oldest return lost; three
//    RETLWs -> third returns the last top value, stk_unf=1.
//  - ADDWF PCL with pclwe=1, pclin=0x40, pa=2'b10 -> next pc=0x440, 1 bubble;
//    pc=7FF with no event -> wraps to 000.

Source files
------------

// File: rtl/pc_seq.sv
// RISC8 program counter and fetch sequencer: PC, return stack and
// instruction register, with flush-based resolution of jumps and skips.
module pc_seq #(
    parameter int PC_WIDTH = 11,
    parameter int STACK_DEPTH = 2,
    parameter logic [PC_WIDTH-1:0] RESET_VEC = {PC_WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] romaddr,
    input  logic [11:0]         romdata,
    output logic [11:0]         inst,
    output logic                squashed,
    input  logic                aluz,
    input  logic                pclwe,
    input  logic [7:0]          pclin,
    input  logic [1:0]          pa,
    output logic                stk_ovf,
    output logic                stk_unf
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] stk [STACK_DEPTH];
    logic [CW-1:0]       cnt;
    logic                full;
    logic                flush;
    logic                push;
    logic                pop;
    logic                is_retlw;
    logic                is_call;
    logic                is_goto;
    logic                skip;
    logic [10:0]         call_t;
    logic [10:0]         goto_t;
    logic [10:0]         pcl_t;

    assign romaddr = pc;
    assign pc_inc  = pc + 1'b1;
    assign full    = (cnt == CW'(STACK_DEPTH));

    assign is_retlw = (inst[11:8] == 4'b1000);
    assign is_call  = (inst[11:8] == 4'b1001);
    assign is_goto  = (inst[11:9] == 3'b101);

    // DECFSZ/INCFSZ and BTFSC skip on zero, BTFSS on nonzero
    assign skip = ((inst[11:6] == 6'b001011) && aluz)
               || ((inst[11:6] == 6'b001111) && aluz)
               || ((inst[11:8] == 4'b0110) && aluz)
               || ((inst[11:8] == 4'b0111) && !aluz);

    // Full 11-bit targets; upper page bits fall away for narrower PCs
    assign call_t = {pa, 1'b0, inst[7:0]};
    assign goto_t = {pa, inst[8:0]};
    assign pcl_t  = {pa, 1'b0, pclin};

    always_comb begin
        next_pc = pc_inc;
        flush   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (!squashed) begin
            priority case (1'b1)
                is_retlw: begin
                    next_pc = stk[0];
                    pop     = 1'b1;
                    flush   = 1'b1;
                end
                is_call: begin
                    next_pc = call_t[PC_WIDTH-1:0];
                    push    = 1'b1;
                    flush   = 1'b1;
                end
                is_goto: begin
                    next_pc = goto_t[PC_WIDTH-1:0];
                    flush   = 1'b1;
                end
                pclwe: begin
                    next_pc = pcl_t[PC_WIDTH-1:0];
                    flush   = 1'b1;
                end
                skip: begin
                    flush = 1'b1;
                end
                default: begin
                    flush = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_VEC;
            inst     <= 12'h000;
            squashed <= 1'b1;
        end else if (!stall) begin
            pc       <= next_pc;
            inst     <= flush ? 12'h000 : romdata;
            squashed <= flush;
        end
    end

    // Push shifts down dropping the deepest; pop shifts up keeping the deepest
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk[i] <= '0;
            end
            cnt     <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (!stall) begin
            if (push) begin
                for (int i = STACK_DEPTH - 1; i > 0; i--) begin
                    stk[i] <= stk[i-1];
                end
                stk[0] <= pc;
                if (full) begin
                    stk_ovf <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (pop) begin
                if (cnt == '0) begin
                    stk_unf <= 1'b1;
                end else begin
                    for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                        stk[i] <= stk[i+1];
                    end
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule
